// File: rtl/riscv_defines.sv
// Shared RV32I decode definitions: opcodes, control encodings, the decoded
// control payload and the immediate/ALU decode helpers.
package riscv_defines;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 32;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_J    = 3'd4
    } imm_src_e;

    typedef struct packed {
        logic        regWrite;
        logic        aluSrc;
        logic        memWrite;
        logic        branch;
        logic        jump;
        result_src_e resultSrc;
        alu_ctrl_e   aluControl;
        imm_src_e    immSrc;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        regWrite:   1'b0,
        aluSrc:     1'b0,
        memWrite:   1'b0,
        branch:     1'b0,
        jump:       1'b0,
        resultSrc:  RES_ALU,
        aluControl: ALU_ADD,
        immSrc:     IMM_NONE
    };

    // Opcode bits are not needed to build any immediate, so only [31:7] is passed.
    function automatic logic [XLEN-1:0] extendImm(input logic [31:7] instr,
                                                  input imm_src_e   immSrc);
        logic [XLEN-1:0] imm;
        case (immSrc)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

    function automatic alu_ctrl_e aluDecode(input logic [2:0] funct3,
                                            input logic       subSel);
        alu_ctrl_e op;
        case (funct3)
            3'b000:  op = subSel ? ALU_SUB : ALU_ADD;
            3'b010:  op = ALU_SLT;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/register_file.sv
// Architectural 32x32 register file: one write port, two combinational read
// ports that bypass a same-cycle writeback.
module register_file
    import riscv_defines::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] readAddr1,
    input  logic [REG_AW-1:0] readAddr2,
    input  logic              writeEn,
    input  logic [REG_AW-1:0] writeAddr,
    input  logic [XLEN-1:0]   writeData,
    output logic [XLEN-1:0]   readData1_c,
    output logic [XLEN-1:0]   readData2_c
);

    logic [XLEN-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (writeEn && (writeAddr != '0)) begin
            regs[writeAddr] <= writeData;
        end
    end

    // x0 wins over the bypass so a discarded x0 write never leaks through.
    always_comb begin
        readData1_c = regs[readAddr1];
        if (readAddr1 == '0) begin
            readData1_c = '0;
        end else if (writeEn && (writeAddr == readAddr1)) begin
            readData1_c = writeData;
        end
    end

    always_comb begin
        readData2_c = regs[readAddr2];
        if (readAddr2 == '0) begin
            readData2_c = '0;
        end else if (writeEn && (writeAddr == readAddr2)) begin
            readData2_c = writeData;
        end
    end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, register read, immediate extension and
// the ID/EX pipeline register feeding execute.
module decode_cycle
    import riscv_defines::*;
#(
    parameter logic [31:0] RESET_PC_E = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   InstrD,
    input  logic [XLEN-1:0]   PCD,
    input  logic [XLEN-1:0]   PCPlus4D,
    input  logic              RegWriteW,
    input  logic [REG_AW-1:0] RDW,
    input  logic [XLEN-1:0]   ResultW,
    input  logic              FlushE,
    output logic              RegWriteE,
    output logic              ALUSrcE,
    output logic              MemWriteE,
    output logic              BranchE,
    output logic              JumpE,
    output logic [1:0]        ResultSrcE,
    output logic [2:0]        ALUControlE,
    output logic [XLEN-1:0]   RD1E,
    output logic [XLEN-1:0]   RD2E,
    output logic [XLEN-1:0]   ImmExtE,
    output logic [REG_AW-1:0] RS1E,
    output logic [REG_AW-1:0] RS2E,
    output logic [REG_AW-1:0] RDE,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E
);

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [REG_AW-1:0] rs1D;
    logic [REG_AW-1:0] rs2D;
    logic [REG_AW-1:0] rdD;
    ctrl_t             ctrlD;
    logic [XLEN-1:0]   immExtD;
    logic [XLEN-1:0]   rd1D;
    logic [XLEN-1:0]   rd2D;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign rs1D   = InstrD[19:15];
    assign rs2D   = InstrD[24:20];
    assign rdD    = InstrD[11:7];

    register_file u_regFile (
        .clk         (clk),
        .rst         (rst),
        .readAddr1   (rs1D),
        .readAddr2   (rs2D),
        .writeEn     (RegWriteW),
        .writeAddr   (RDW),
        .writeData   (ResultW),
        .readData1_c (rd1D),
        .readData2_c (rd2D)
    );

    // Main control decode; unsupported opcodes fall through as a bubble.
    always_comb begin
        ctrlD = CTRL_BUBBLE;
        case (opcode)
            OP_RTYPE: begin
                ctrlD.regWrite   = 1'b1;
                ctrlD.aluControl = aluDecode(funct3, InstrD[30]);
            end
            OP_IALU: begin
                ctrlD.regWrite   = 1'b1;
                ctrlD.aluSrc     = 1'b1;
                ctrlD.aluControl = aluDecode(funct3, 1'b0);
                ctrlD.immSrc     = IMM_I;
            end
            OP_LOAD: begin
                ctrlD.regWrite  = 1'b1;
                ctrlD.aluSrc    = 1'b1;
                ctrlD.resultSrc = RES_MEM;
                ctrlD.immSrc    = IMM_I;
            end
            OP_STORE: begin
                ctrlD.memWrite = 1'b1;
                ctrlD.aluSrc   = 1'b1;
                ctrlD.immSrc   = IMM_S;
            end
            OP_BRANCH: begin
                ctrlD.branch     = 1'b1;
                ctrlD.aluControl = ALU_SUB;
                ctrlD.immSrc     = IMM_B;
            end
            OP_JAL: begin
                ctrlD.regWrite  = 1'b1;
                ctrlD.jump      = 1'b1;
                ctrlD.resultSrc = RES_PC4;
                ctrlD.immSrc    = IMM_J;
            end
            default: ;
        endcase
    end

    assign immExtD = extendImm(InstrD[31:7], ctrlD.immSrc);

    // ID/EX register: loads every cycle, flush inserts a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            MemWriteE   <= 1'b0;
            BranchE     <= 1'b0;
            JumpE       <= 1'b0;
            ResultSrcE  <= '0;
            ALUControlE <= '0;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            RS1E        <= '0;
            RS2E        <= '0;
            RDE         <= '0;
            PCE         <= RESET_PC_E;
            PCPlus4E    <= RESET_PC_E;
        end else if (FlushE) begin
            RegWriteE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            MemWriteE   <= 1'b0;
            BranchE     <= 1'b0;
            JumpE       <= 1'b0;
            ResultSrcE  <= '0;
            ALUControlE <= '0;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            RS1E        <= '0;
            RS2E        <= '0;
            RDE         <= '0;
            PCE         <= RESET_PC_E;
            PCPlus4E    <= RESET_PC_E;
        end else begin
            RegWriteE   <= ctrlD.regWrite;
            ALUSrcE     <= ctrlD.aluSrc;
            MemWriteE   <= ctrlD.memWrite;
            BranchE     <= ctrlD.branch;
            JumpE       <= ctrlD.jump;
            ResultSrcE  <= ctrlD.resultSrc;
            ALUControlE <= ctrlD.aluControl;
            RD1E        <= rd1D;
            RD2E        <= rd2D;
            ImmExtE     <= immExtD;
            RS1E        <= rs1D;
            RS2E        <= rs2D;
            RDE         <= rdD;
            PCE         <= PCD;
            PCPlus4E    <= PCPlus4D;
        end
    end

endmodule

// File: tb/tb_decode_cycle.sv
// Directed self-checking bench for decode_cycle.
module tb_decode_cycle;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        clk;
    logic        rst;
    logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
    logic        RegWriteW, FlushE;
    logic [4:0]  RDW;
    logic        RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  RS1E, RS2E, RDE;
    logic [9:0]  ctlE;

    int checks = 0;
    int errors = 0;

    decode_cycle #(.RESET_PC_E(RST_PC)) dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .BranchE(BranchE), .JumpE(JumpE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .RS1E(RS1E), .RS2E(RS2E), .RDE(RDE), .PCE(PCE), .PCPlus4E(PCPlus4E)
    );

    // {RegWrite, ALUSrc, MemWrite, Branch, Jump, ResultSrc[1:0], ALUControl[2:0]}
    assign ctlE = {RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE, ResultSrcE, ALUControlE};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        checks++; if (ctlE !== 10'd0) begin errors++; $display("FAIL reset ctl: got %b expected %b", ctlE, 10'd0); end
        checks++; if ({RD1E, RD2E, ImmExtE} !== 96'd0) begin errors++; $display("FAIL reset data: got %h %h %h expected 0", RD1E, RD2E, ImmExtE); end
        checks++; if ({RS1E, RS2E, RDE} !== 15'd0) begin errors++; $display("FAIL reset idx: got %h expected 0", {RS1E, RS2E, RDE}); end
        checks++; if (PCE !== RST_PC || PCPlus4E !== RST_PC) begin errors++; $display("FAIL reset pc: got %h %h expected %h", PCE, PCPlus4E, RST_PC); end
        step();
        checks++; if (PCE !== RST_PC || ctlE !== 10'd0) begin errors++; $display("FAIL reset held: got pc %h ctl %b expected %h 0", PCE, ctlE, RST_PC); end
        #2 rst = 1'b1;
    endtask

    task automatic test_addi();
        InstrD = 32'h00500093; PCD = 32'h100; PCPlus4D = 32'h104;
        step();
        checks++; if (ctlE !== 10'b1100000000) begin errors++; $display("FAIL addi ctl: got %b expected %b", ctlE, 10'b1100000000); end
        checks++; if (ImmExtE !== 32'd5) begin errors++; $display("FAIL addi imm: got %h expected %h", ImmExtE, 32'd5); end
        checks++; if (RDE !== 5'd1 || RD1E !== 32'd0) begin errors++; $display("FAIL addi rd/rd1: got %0d %h expected 1 0", RDE, RD1E); end
        checks++; if (PCE !== 32'h100 || PCPlus4E !== 32'h104) begin errors++; $display("FAIL addi pc: got %h %h expected 100 104", PCE, PCPlus4E); end
    endtask

    task automatic test_bypass();
        RegWriteW = 1'b1; RDW = 5'd2; ResultW = 32'hDEADBEEF; InstrD = 32'h002101B3;
        step();
        checks++; if (RD1E !== 32'hDEADBEEF || RD2E !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass: got %h %h expected deadbeef", RD1E, RD2E); end
        checks++; if (ctlE !== 10'b1000000000 || RDE !== 5'd3 || ImmExtE !== 32'd0) begin errors++; $display("FAIL add decode: got %b rd %0d imm %h expected 1000000000 3 0", ctlE, RDE, ImmExtE); end
        RegWriteW = 1'b0; ResultW = 32'h0;
        step();
        checks++; if (RD1E !== 32'hDEADBEEF) begin errors++; $display("FAIL regfile store: got %h expected deadbeef", RD1E); end
    endtask

    task automatic test_x0();
        RegWriteW = 1'b1; RDW = 5'd0; ResultW = 32'h1234; InstrD = 32'h000000B3;
        step();
        checks++; if (RD1E !== 32'd0) begin errors++; $display("FAIL x0 bypass: got %h expected 0", RD1E); end
        RegWriteW = 1'b0;
        step();
        checks++; if (RD1E !== 32'd0 || RD2E !== 32'd0) begin errors++; $display("FAIL x0 read: got %h %h expected 0", RD1E, RD2E); end
    endtask

    task automatic test_beq();
        InstrD = 32'hFE000EE3; PCD = 32'h40; PCPlus4D = 32'h44;
        step();
        checks++; if (ctlE !== 10'b0001000001) begin errors++; $display("FAIL beq ctl: got %b expected %b", ctlE, 10'b0001000001); end
        checks++; if (ImmExtE !== 32'hFFFFFFFC) begin errors++; $display("FAIL beq imm: got %h expected fffffffc", ImmExtE); end
        checks++; if (PCE !== 32'h40) begin errors++; $display("FAIL beq pc: got %h expected 40", PCE); end
    endtask

    task automatic test_flush();
        InstrD = 32'h00532423; FlushE = 1'b1;
        RegWriteW = 1'b1; RDW = 5'd6; ResultW = 32'h100;
        step();
        checks++; if (ctlE !== 10'd0 || ImmExtE !== 32'd0) begin errors++; $display("FAIL flush ctl: got %b imm %h expected 0", ctlE, ImmExtE); end
        checks++; if ({RS1E, RS2E, RDE} !== 15'd0 || RD1E !== 32'd0) begin errors++; $display("FAIL flush idx: got %h rd1 %h expected 0", {RS1E, RS2E, RDE}, RD1E); end
        checks++; if (PCE !== RST_PC || PCPlus4E !== RST_PC) begin errors++; $display("FAIL flush pc: got %h %h expected %h", PCE, PCPlus4E, RST_PC); end
        FlushE = 1'b0; RegWriteW = 1'b0; ResultW = 32'h0;
        step();
        checks++; if (ctlE !== 10'b0110000000) begin errors++; $display("FAIL sw ctl: got %b expected %b", ctlE, 10'b0110000000); end
        checks++; if (ImmExtE !== 32'd8) begin errors++; $display("FAIL sw imm: got %h expected 8", ImmExtE); end
        checks++; if (RS1E !== 5'd6 || RS2E !== 5'd5) begin errors++; $display("FAIL sw idx: got %0d %0d expected 6 5", RS1E, RS2E); end
        checks++; if (RD1E !== 32'h100) begin errors++; $display("FAIL write during flush: got %h expected 100", RD1E); end
    endtask

    task automatic test_decode_table();
        logic [31:0] instrs [9];
        logic [9:0]  expCtl [9];
        logic [31:0] expImm [9];
        instrs[0] = 32'h40208233; expCtl[0] = 10'b1000000001; expImm[0] = 32'h0;        // sub
        instrs[1] = 32'h003160B3; expCtl[1] = 10'b1000000011; expImm[1] = 32'h0;        // or
        instrs[2] = 32'h003170B3; expCtl[2] = 10'b1000000010; expImm[2] = 32'h0;        // and
        instrs[3] = 32'h003110B3; expCtl[3] = 10'b1000000000; expImm[3] = 32'h0;        // sll -> add
        instrs[4] = 32'hFFF12093; expCtl[4] = 10'b1100000101; expImm[4] = 32'hFFFFFFFF; // slti -1
        instrs[5] = 32'h40000093; expCtl[5] = 10'b1100000000; expImm[5] = 32'h400;      // addi, bit30 set
        instrs[6] = 32'h00412083; expCtl[6] = 10'b1100001000; expImm[6] = 32'h4;        // lw
        instrs[7] = 32'h008000EF; expCtl[7] = 10'b1000110000; expImm[7] = 32'h8;        // jal
        instrs[8] = 32'h123450B7; expCtl[8] = 10'b0000000000; expImm[8] = 32'h0;        // lui: bubble
        for (int i = 0; i < 9; i++) begin
            InstrD = instrs[i];
            step();
            checks++; if (ctlE !== expCtl[i]) begin errors++; $display("FAIL decode[%0d] ctl: got %b expected %b", i, ctlE, expCtl[i]); end
            checks++; if (ImmExtE !== expImm[i]) begin errors++; $display("FAIL decode[%0d] imm: got %h expected %h", i, ImmExtE, expImm[i]); end
        end
        checks++; if (RDE !== 5'd1) begin errors++; $display("FAIL bubble rd index: got %0d expected 1", RDE); end
    endtask

    task automatic test_reset_mid();
        RegWriteW = 1'b1; RDW = 5'd7; ResultW = 32'h55; InstrD = 32'h00000013;
        step();
        RegWriteW = 1'b0; ResultW = 32'h0; InstrD = 32'h00738433; PCD = 32'h200; PCPlus4D = 32'h204;
        step();
        checks++; if (RD1E !== 32'h55 || RD2E !== 32'h55) begin errors++; $display("FAIL x7 load: got %h %h expected 55", RD1E, RD2E); end
        RegWriteW = 1'b1; RDW = 5'd7; ResultW = 32'h99;
        #2 rst = 1'b0;
        #1;
        checks++; if (ctlE !== 10'd0 || RD1E !== 32'd0 || RDE !== 5'd0) begin errors++; $display("FAIL async reset: got ctl %b rd1 %h rd %0d expected 0", ctlE, RD1E, RDE); end
        checks++; if (PCE !== RST_PC) begin errors++; $display("FAIL async reset pc: got %h expected %h", PCE, RST_PC); end
        step();
        RegWriteW = 1'b0; ResultW = 32'h0;
        rst = 1'b1;
        step();
        checks++; if (RD1E !== 32'd0 || RD2E !== 32'd0) begin errors++; $display("FAIL x7 after reset: got %h %h expected 0", RD1E, RD2E); end
        checks++; if (ctlE !== 10'b1000000000 || PCE !== 32'h200) begin errors++; $display("FAIL decode after reset: got %b pc %h expected 1000000000 200", ctlE, PCE); end
    endtask

    initial begin
        InstrD = '0; PCD = '0; PCPlus4D = '0;
        RegWriteW = 1'b0; RDW = '0; ResultW = '0; FlushE = 1'b0;
        test_reset();
        test_addi();
        test_bypass();
        test_x0();
        test_beq();
        test_flush();
        test_decode_table();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
